dbus_arbiter: RTL and testbench

//  Two-master arbiter for the shared data port (port 1) of the imem/dmem dual-port RAM.

---
 rtl/dbus_arbiter_pkg.sv | 11 +
 rtl/dbus_arbiter_rr_pick2.sv | 33 +++
 rtl/dbus_arbiter.sv | 114 +++++++++++
 tb/tb_dbus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-port arbiter: ownership states and master indices.
package dbus_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;
endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// Combinational winner selection for two masters: round-robin with a cap on
// consecutive contested grants to the current owner.
module rr_pick2
    import dbus_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BW        = $clog2(MAX_BURST) + 1
) (
    input  logic [1:0]    req,
    input  logic [1:0]    state,
    input  logic          last,
    input  logic [BW-1:0] burst_cnt,
    output logic [1:0]    gnt
);
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST - 1);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                // Under contention the owner keeps the port until the cap is reached.
                case (state)
                    ST_OWN0: gnt = (burst_cnt < BURST_LIM) ? 2'b01 : 2'b10;
                    ST_OWN1: gnt = (burst_cnt < BURST_LIM) ? 2'b10 : 2'b01;
                    default: gnt = (last == M_DBG) ? 2'b01 : 2'b10;
                endcase
            end
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the shared RAM data port: one single-beat access per
// cycle, round-robin with burst cap, registered read data one cycle after grant.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DWIDTH/8-1:0]   m0_be,
    input  logic [AWIDTH-1:0]     m0_addr,
    input  logic [DWIDTH-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DWIDTH-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DWIDTH/8-1:0]   m1_be,
    input  logic [AWIDTH-1:0]     m1_addr,
    input  logic [DWIDTH-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DWIDTH-1:0]     m1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DWIDTH/8-1:0]   mem_be,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic [DWIDTH-1:0]     mem_rdata
);
    localparam int BW = $clog2(MAX_BURST) + 1;

    state_t          state, state_nxt;
    logic            last, last_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic [1:0]      req, pick, gnt;
    logic            sel;
    logic [1:0]      rvalid_p1;
    logic [DWIDTH-1:0] rdata0_p1, rdata1_p1;

    assign req = {m1_req, m0_req};

    rr_pick2 #(
        .MAX_BURST (MAX_BURST),
        .BW        (BW)
    ) u_pick (
        .req       (req),
        .state     (state),
        .last      (last),
        .burst_cnt (burst_cnt),
        .gnt       (pick)
    );

    // Gated by reset so no access, and in particular no write, leaks out while n_rst is low.
    assign gnt    = pick & {2{n_rst}};
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign sel    = gnt[1];

    assign mem_en    = |gnt;
    assign mem_we    = mem_en & (sel ? m1_we : m0_we);
    assign mem_be    = sel ? m1_be    : m0_be;
    assign mem_addr  = sel ? m1_addr  : m0_addr;
    assign mem_wdata = sel ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            last      <= M_DBG;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        last_nxt  = last;
        burst_nxt = '0;
        if (gnt[0]) begin
            state_nxt = ST_OWN0;
            last_nxt  = M_CPU;
            if (state == ST_OWN0 && req[1]) burst_nxt = burst_cnt + 1'b1;
        end else if (gnt[1]) begin
            state_nxt = ST_OWN1;
            last_nxt  = M_DBG;
            if (state == ST_OWN1 && req[0]) burst_nxt = burst_cnt + 1'b1;
        end
    end

    // ---- stage p1: registered read return ----
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rvalid_p1 <= 2'b00;
            rdata0_p1 <= '0;
            rdata1_p1 <= '0;
        end else begin
            rvalid_p1 <= gnt & ~{m1_we, m0_we};
            if (gnt[0] && !m0_we) rdata0_p1 <= mem_rdata;
            if (gnt[1] && !m1_we) rdata1_p1 <= mem_rdata;
        end
    end

    assign m0_rvalid = rvalid_p1[0];
    assign m1_rvalid = rvalid_p1[1];
    assign m0_rdata  = rdata0_p1;
    assign m1_rdata  = rdata1_p1;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration and memory model.
module tb_dbus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_d = 2'b00;
    logic [1:0]  we_d  = 2'b00;
    logic [3:0]  be_d    [2];
    logic [31:0] addr_d  [2];
    logic [31:0] wdata_d [2];

    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic mem_en, mem_we;
    logic [3:0] mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dbus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .n_rst(n_rst),
        .m0_req(req_d[0]), .m0_we(we_d[0]), .m0_be(be_d[0]), .m0_addr(addr_d[0]),
        .m0_wdata(wdata_d[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req_d[1]), .m1_we(we_d[1]), .m1_be(be_d[1]), .m1_addr(addr_d[1]),
        .m1_wdata(wdata_d[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM environment: asynchronous read, byte-enabled write at the clock edge.
    logic [31:0] ram [64];
    logic [31:0] init_img [64];
    logic ram_init = 1'b1;
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_img[i];
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct { int due; logic [31:0] data; } rd_t;
    rd_t rq0[$];
    rd_t rq1[$];
    logic [31:0] mdl [64];
    logic [31:0] hold [2];
    int prev_owner = -1;
    int last_m = 1;
    int streak = 0;
    int last_w = -1;
    bit rec = 1'b0;
    int gseq[$];

    task automatic model_reset();
        prev_owner = -1;
        last_m = 1;
        streak = 0;
        rq0.delete();
        rq1.delete();
        hold[0] = '0;
        hold[1] = '0;
    endtask

    // Expected grant from the arbitration rules, then commit the access to the model.
    task automatic check_cycle();
        int w;
        int idx;
        bit both;
        logic [31:0] eg;
        rd_t e;
        w = -1;
        both = (req_d == 2'b11);
        if (!n_rst) model_reset();
        else if (req_d == 2'b01) w = 0;
        else if (req_d == 2'b10) w = 1;
        else if (both) begin
            if (prev_owner < 0)        w = (last_m == 1) ? 0 : 1;
            else if (streak < MB)      w = prev_owner;
            else                       w = 1 - prev_owner;
        end
        eg = (w < 0) ? 32'd0 : ((w == 0) ? 32'd1 : 32'd2);
        chk("gnt", {30'd0, m1_gnt, m0_gnt}, eg);
        chk("mem_en", 32'(mem_en), 32'(w >= 0));
        chk("mem_we", 32'(mem_we), 32'((w >= 0) && we_d[w[0]]));
        if (w >= 0) begin
            chk("mem_addr", mem_addr, addr_d[w]);
            chk("mem_be", 32'(mem_be), 32'(be_d[w]));
            chk("mem_wdata", mem_wdata, wdata_d[w]);
            idx = int'(addr_d[w][7:2]);
            if (we_d[w[0]]) begin
                for (int b = 0; b < 4; b++)
                    if (be_d[w][b]) mdl[idx][8*b +: 8] = wdata_d[w][8*b +: 8];
            end else begin
                e.due = cyc + 1;
                e.data = mdl[idx];
                if (w == 0) rq0.push_back(e); else rq1.push_back(e);
            end
            if (both && w == prev_owner) streak++; else streak = 1;
            prev_owner = w;
            last_m = w;
            if (rec) gseq.push_back(w);
        end else if (n_rst) begin
            prev_owner = -1;
        end
        last_w = w;
    endtask

    // Monitor: pop expected read responses when the DUT presents rvalid.
    task automatic mon(input int m);
        logic rv;
        logic [31:0] rd;
        bit have;
        bit exp_rv;
        rd_t e;
        rv = (m == 1) ? m1_rvalid : m0_rvalid;
        rd = (m == 1) ? m1_rdata : m0_rdata;
        have = (m == 1) ? (rq1.size() > 0) : (rq0.size() > 0);
        if (have) e = (m == 1) ? rq1[0] : rq0[0];
        while (have && e.due < cyc) begin
            if (m == 1) void'(rq1.pop_front()); else void'(rq0.pop_front());
            have = (m == 1) ? (rq1.size() > 0) : (rq0.size() > 0);
            if (have) e = (m == 1) ? rq1[0] : rq0[0];
        end
        exp_rv = have && (e.due == cyc);
        chk((m == 1) ? "m1_rvalid" : "m0_rvalid", 32'(rv), 32'(exp_rv));
        if (exp_rv) begin
            if (m == 1) void'(rq1.pop_front()); else void'(rq0.pop_front());
            chk((m == 1) ? "m1_rdata" : "m0_rdata", rd, e.data);
            hold[m] = e.data;
        end else if (!rv) begin
            chk((m == 1) ? "m1_rdata_hold" : "m0_rdata_hold", rd, hold[m]);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic new_read(input int m);
        we_d[m]    = 1'b0;
        be_d[m]    = 4'hF;
        addr_d[m]  = $urandom;
        wdata_d[m] = $urandom;
    endtask

    task automatic new_rand(input int m);
        req_d[m]   = ($urandom_range(0, 3) != 0);
        we_d[m]    = 1'($urandom_range(0, 1));
        be_d[m]    = 4'($urandom_range(1, 15));
        addr_d[m]  = $urandom;
        wdata_d[m] = $urandom;
    endtask

    int exp3 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int exp5 [4] = '{1, 1, 1, 0};
    int n1;

    initial begin
        for (int i = 0; i < 64; i++) init_img[i] = $urandom;
        init_img[4]  = 32'hDEADBEEF;
        init_img[16] = 32'hAAAAAAAA;
        for (int i = 0; i < 64; i++) mdl[i] = init_img[i];
        model_reset();
        new_read(0);
        new_read(1);
        req_d = 2'b11;

        // Reset held with both masters requesting: no grants.
        for (int i = 0; i < 3; i++) step();
        ram_init = 1'b0;
        gseq.delete();
        rec = 1'b1;
        n_rst = 1'b1;

        // Continuous contention after release: master 0 first, bursts of MB.
        for (int i = 0; i < 9; i++) begin
            step();
            if (last_w >= 0) new_read(last_w);
        end
        rec = 1'b0;
        chk("burst_seq_len", 32'(gseq.size()), 32'd9);
        for (int i = 0; i < 9 && i < gseq.size(); i++)
            chk($sformatf("burst_seq[%0d]", i), 32'(gseq[i]), 32'(exp3[i]));

        // Single read of a known word, data one cycle after grant.
        req_d = 2'b01; we_d[0] = 1'b0; addr_d[0] = 32'h10;
        step();
        req_d = 2'b00;
        chk("t2_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t2_rdata", m0_rdata, 32'hDEADBEEF);
        step();
        chk("t2_rvalid_drop", 32'(m0_rvalid), 32'd0);

        // Partial write by master 1, then read-back by master 0.
        req_d = 2'b10; we_d[1] = 1'b1; be_d[1] = 4'b0011;
        addr_d[1] = 32'h40; wdata_d[1] = 32'h12345678;
        #1;
        chk("t4_mem_we", 32'(mem_we), 32'd1);
        chk("t4_mem_be", 32'(mem_be), 32'h3);
        step();
        req_d = 2'b01; we_d[0] = 1'b0; addr_d[0] = 32'h40;
        step();
        req_d = 2'b00;
        chk("t4_rdata", m0_rdata, 32'hAAAA5678);

        // Master 1 alone for 10 cycles, then contention.
        n1 = 0;
        req_d = 2'b10;
        for (int i = 0; i < 10; i++) begin
            new_rand(1);
            req_d[1] = 1'b1;
            step();
            if (last_w == 1) n1++;
        end
        chk("t5_m1_gnts", 32'(n1), 32'd10);
        gseq.delete();
        rec = 1'b1;
        new_read(0);
        new_read(1);
        req_d = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_w >= 0) new_read(last_w);
        end
        rec = 1'b0;
        chk("t5_seq_len", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gseq.size(); i++)
            chk($sformatf("t5_seq[%0d]", i), 32'(gseq[i]), 32'(exp5[i]));

        // Reset in the cycle after a read grant drops the pending response.
        req_d = 2'b01; new_read(0);
        step();
        chk("t6_rvalid_pre", 32'(m0_rvalid), 32'd1);
        n_rst = 1'b0;
        model_reset();
        #1;
        chk("t6_rvalid_rst", 32'(m0_rvalid), 32'd0);
        chk("t6_rdata_rst", m0_rdata, 32'd0);
        req_d = 2'b11; we_d = 2'b11;
        for (int i = 0; i < 3; i++) step();
        n_rst = 1'b1;

        // Randomized traffic; a master keeps its request and payload until granted.
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++)
                if (!(req_d[m] && last_w != m && $urandom_range(0, 7) != 0)) new_rand(m);
            step();
        end

        req_d = 2'b00;
        for (int i = 0; i < 3; i++) step();
        chk("rq_drained", 32'(rq0.size() + rq1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
